// File: rtl/lsu_pkg.sv
// Shared definitions for the mem_access load/store stage: funct3 codes, fault codes,
// FSM states and the data-memory request payload.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'b00,
    FLT_MISAL   = 2'b01,
    FLT_ACCESS  = 2'b10,
    FLT_ILLEGAL = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_e;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [STRB_W-1:0] wstrb;
    logic [XLEN-1:0]   wdata;
  } dmem_req_t;

  // Stores only have B/H/W; loads add the unsigned BU/HU variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {F3_B, F3_H, F3_W};
    else          return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/data replication and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic              i_is_store,
  input  logic [2:0]        i_st_funct3,
  input  logic [1:0]        i_st_off,
  input  logic [XLEN-1:0]   i_st_data,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [XLEN-1:0]   o_wdata,
  input  logic [2:0]        i_ld_funct3,
  input  logic [1:0]        i_ld_off,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   o_ldata
);

  logic [XLEN-1:0] w_byte_sh;
  logic [XLEN-1:0] w_half_sh;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  // Store lanes: shift the enables to the addressed lane, replicate data across lanes.
  always_comb begin
    o_wstrb = '0;
    o_wdata = '0;
    if (i_is_store) begin
      case (i_st_funct3)
        F3_B: begin
          o_wstrb = STRB_W'(4'b0001 << i_st_off);
          o_wdata = {4{i_st_data[7:0]}};
        end
        F3_H: begin
          o_wstrb = STRB_W'(4'b0011 << {i_st_off[1], 1'b0});
          o_wdata = {2{i_st_data[15:0]}};
        end
        F3_W: begin
          o_wstrb = 4'b1111;
          o_wdata = i_st_data;
        end
        default: ;
      endcase
    end
  end

  assign w_byte_sh = i_rdata >> {i_ld_off, 3'b000};
  assign w_half_sh = i_rdata >> {i_ld_off[1], 4'b0000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = w_half_sh[15:0];

  // Load extract: pick byte/half by address, then sign- or zero-extend.
  always_comb begin
    o_ldata = '0;
    case (i_ld_funct3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_W:    o_ldata = i_rdata;
      F3_BU:   o_ldata = {24'h0, w_byte};
      F3_HU:   o_ldata = {16'h0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: one req/gnt/rvalid data-memory transaction per op,
// result handed to writeback with valid/ready.
// Build option: MEM_MISALIGN_TRAP_EN makes misaligned H/W accesses fault instead of truncating.
module mem_access
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_store_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_alu_out,
  output logic [XLEN-1:0]   out_loaddata,
  output logic              out_is_load,
  output logic [1:0]        out_fault,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [STRB_W-1:0] dmem_wstrb,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_dmem_req;
  logic [CNT_W-1:0]  r_cnt;
  dmem_req_t         r_dmem;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [XLEN-1:0]   r_out_alu_out;
  logic [XLEN-1:0]   r_out_loaddata;
  logic              r_out_is_load;
  fault_e            r_out_fault;

  logic              w_accept;
  logic              w_is_mem;
  logic              w_illegal;
  logic              w_misal;
  fault_e            w_fault_in;
  logic              w_timeout;
  logic              w_tmo;
  logic              w_rsp;
  logic [STRB_W-1:0] w_wstrb;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_ldata;

  assign w_accept  = in_valid && r_in_ready;
  assign w_is_mem  = in_is_load || in_is_store;
  assign w_illegal = w_is_mem && !f3_legal(in_is_store, in_funct3);
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misal   = w_is_mem &&
                     (((in_funct3[1:0] == 2'b01) && in_alu_out[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (in_alu_out[1:0] != 2'b00)));
`else
  assign w_misal   = 1'b0;
`endif
  assign w_fault_in = w_illegal ? FLT_ILLEGAL : (w_misal ? FLT_MISAL : FLT_NONE);
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  lsu_align u_align (
    .i_is_store  (in_is_store),
    .i_st_funct3 (in_funct3),
    .i_st_off    (in_alu_out[1:0]),
    .i_st_data   (in_store_data),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_addr_lo),
    .i_rdata     (dmem_rdata),
    .o_ldata     (w_ldata)
  );

  // Next-state logic; a bus response in the same cycle wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo       = 1'b0;
    w_rsp       = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept)
                w_state_nxt = (w_is_mem && (w_fault_in == FLT_NONE)) ? S_REQ : S_DONE;
      S_REQ:  if (dmem_gnt)       w_state_nxt = S_WAIT;
              else if (w_timeout) begin w_state_nxt = S_DONE; w_tmo = 1'b1; end
      S_WAIT: if (dmem_rvalid)    begin w_state_nxt = S_DONE; w_rsp = 1'b1; end
              else if (w_timeout) begin w_state_nxt = S_DONE; w_tmo = 1'b1; end
      S_DONE: if (out_ready)      w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus handshake flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dmem_req  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_dmem_req  <= (w_state_nxt == S_REQ);
    end
  end

  // REQ+WAIT cycle counter, cleared when a transaction starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_cnt <= '0;
    else if (r_state == S_IDLE && w_state_nxt == S_REQ) r_cnt <= '0;
    else if (r_state == S_REQ || r_state == S_WAIT)     r_cnt <= r_cnt + CNT_W'(1);
  end

  // Operation capture at accept, load data on response, access fault on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmem         <= '0;
      r_funct3       <= '0;
      r_addr_lo      <= '0;
      r_out_alu_out  <= '0;
      r_out_loaddata <= '0;
      r_out_is_load  <= 1'b0;
      r_out_fault    <= FLT_NONE;
    end else begin
      if (w_accept) begin
        r_dmem.we      <= in_is_store;
        r_dmem.addr    <= {in_alu_out[XLEN-1:2], 2'b00};
        r_dmem.wstrb   <= w_wstrb;
        r_dmem.wdata   <= w_wdata;
        r_funct3       <= in_funct3;
        r_addr_lo      <= in_alu_out[1:0];
        r_out_alu_out  <= in_alu_out;
        r_out_loaddata <= '0;
        r_out_is_load  <= in_is_load;
        r_out_fault    <= w_fault_in;
      end
      if (w_rsp && r_out_is_load) r_out_loaddata <= w_ldata;
      if (w_tmo)                  r_out_fault    <= FLT_ACCESS;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_alu_out  = r_out_alu_out;
  assign out_loaddata = r_out_loaddata;
  assign out_is_load  = r_out_is_load;
  assign out_fault    = r_out_fault;
  assign dmem_req     = r_dmem_req;
  assign dmem_we      = r_dmem.we;
  assign dmem_addr    = r_dmem.addr;
  assign dmem_wstrb   = r_dmem.wstrb;
  assign dmem_wdata   = r_dmem.wdata;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a bus responder, a result scoreboard, and
// directed load/store/fault/timeout/reset cases. Honors MEM_MISALIGN_TRAP_EN.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_out, in_store_data;
  logic        out_valid, out_ready, out_is_load;
  logic [31:0] out_alu_out, out_loaddata;
  logic [1:0]  out_fault;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] ld;
    logic        isl;
    logic [1:0]  flt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .in_alu_out(in_alu_out),
    .in_store_data(in_store_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_out(out_alu_out),
    .out_loaddata(out_loaddata), .out_is_load(out_is_load), .out_fault(out_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one op, act as the bus (grant after gnt_wait REQ cycles, rvalid next cycle),
  // then score the result and the writeback handshake.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int gnt_wait, input logic no_gnt,
                        input logic [31:0] exp_ld, input logic [1:0] exp_flt,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input int exp_lat);
    exp_t e;
    exp_t got;
    logic exp_req;
    logic saw_req = 1'b0;
    logic granted = 1'b0;
    logic sent    = 1'b0;
    logic hung    = 1'b0;
    int   lat     = 0;
    int   reqc    = 0;
    exp_req = (ld || st) && (exp_flt == 2'b00 || exp_flt == 2'b10);
    e = '{alu: addr, ld: exp_ld, isl: ld, flt: exp_flt};
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_alu_out = addr; in_store_data = sdata;
    check("in_ready_at_issue", 32'(in_ready), 32'd1);
    forever begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (out_valid) break;
      if (lat > 60) begin
        check("out_valid_timeout", 32'(lat), 32'(exp_lat));
        hung = 1'b1;
        break;
      end
      if (dmem_req && !saw_req) begin
        saw_req = 1'b1;
        check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
        check("dmem_we", 32'(dmem_we), 32'(st));
        check("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_strb));
        if (st) check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (granted && !sent) begin
        dmem_rvalid = 1'b1; dmem_rdata = rdata; sent = 1'b1;
      end else if (dmem_req && !granted && !no_gnt && reqc >= gnt_wait) begin
        dmem_gnt = 1'b1; granted = 1'b1;
      end
      if (dmem_req) reqc++;
    end
    if (!hung) begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("bus_request_seen", 32'(saw_req), 32'(exp_req));
      got = sb.pop_front();
      check("out_alu_out", out_alu_out, got.alu);
      check("out_loaddata", out_loaddata, got.ld);
      check("out_is_load", 32'(out_is_load), 32'(got.isl));
      check("out_fault", 32'(out_fault), 32'(got.flt));
      @(negedge clk);
      check("out_valid_held", 32'(out_valid), 32'd1);
      check("in_ready_while_done", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_ready", 32'(out_valid), 32'd0);
      check("in_ready_after_ready", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_funct3 = 3'b000; in_alu_out = '0; in_store_data = '0; out_ready = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_out_fault", 32'(out_fault), 32'd0);
    check("rst_out_loaddata", out_loaddata, 32'd0);
    check("rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
    rst_n = 1'b1;

    // Loads: full word, signed/unsigned byte and half from various lanes.
    run_op(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 2'b00, 4'h0, 0, 3);
    run_op(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 0, 0, 32'hFFFFFF80, 2'b00, 4'h0, 0, 3);
    run_op(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 0, 0, 32'h00000080, 2'b00, 4'h0, 0, 3);
    run_op(1, 0, 3'b101, 32'h102, 0, 32'h80112233, 0, 0, 32'h00008011, 2'b00, 4'h0, 0, 3);
    run_op(1, 0, 3'b001, 32'h102, 0, 32'h80112233, 1, 0, 32'hFFFF8011, 2'b00, 4'h0, 0, 4);
    run_op(1, 0, 3'b001, 32'h100, 0, 32'h80112233, 0, 0, 32'h00002233, 2'b00, 4'h0, 0, 3);
    // Stores: lane enables and replicated data, late grant.
    run_op(0, 1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 2, 0, 32'h0, 2'b00, 4'b0010, 32'hABABABAB, 5);
    run_op(0, 1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0, 0, 32'h0, 2'b00, 4'b1100, 32'h12341234, 3);
    run_op(0, 1, 3'b010, 32'h104, 32'h89ABCDEF, 32'h0, 0, 0, 32'h0, 2'b00, 4'b1111, 32'h89ABCDEF, 3);
    // Non-memory op passes through in one cycle; illegal funct3 faults without bus access.
    run_op(0, 0, 3'b111, 32'hCAFE0001, 0, 32'h0, 0, 0, 32'h0, 2'b00, 4'h0, 0, 1);
    run_op(1, 0, 3'b011, 32'h100, 0, 32'h0, 0, 0, 32'h0, 2'b11, 4'h0, 0, 1);
    run_op(0, 1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 0, 32'h0, 2'b11, 4'h0, 0, 1);
    run_op(1, 0, 3'b111, 32'h101, 0, 32'h0, 0, 0, 32'h0, 2'b11, 4'h0, 0, 1);
    // Misaligned accesses depend on the trap build option.
`ifdef MEM_MISALIGN_TRAP_EN
    run_op(1, 0, 3'b010, 32'h102, 0, 32'h11223344, 0, 0, 32'h0, 2'b01, 4'h0, 0, 1);
    run_op(1, 0, 3'b001, 32'h101, 0, 32'h1234F00D, 0, 0, 32'h0, 2'b01, 4'h0, 0, 1);
`else
    run_op(1, 0, 3'b010, 32'h102, 0, 32'h11223344, 0, 0, 32'h11223344, 2'b00, 4'h0, 0, 3);
    run_op(1, 0, 3'b001, 32'h101, 0, 32'h1234F00D, 0, 0, 32'hFFFFF00D, 2'b00, 4'h0, 0, 3);
`endif
    // No grant: access fault after 16 bus cycles; a late rvalid must be dropped.
    run_op(1, 0, 3'b010, 32'h200, 0, 32'h0, 0, 1, 32'h0, 2'b10, 4'h0, 0, 17);
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("late_rvalid_no_out_valid", 32'(out_valid), 32'd0);
    check("late_rvalid_in_ready", 32'(in_ready), 32'd1);
    run_op(1, 0, 3'b010, 32'h204, 0, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 2'b00, 4'h0, 0, 3);

    // Reset while waiting for read data: request and result vanish, stage restarts clean.
    @(negedge clk);
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
    in_alu_out = 32'h300;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_case_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("rst_case_wait_no_req", 32'(dmem_req), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dmem_req", 32'(dmem_req), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    run_op(1, 0, 3'b100, 32'h301, 0, 32'hA5C3E1F0, 0, 0, 32'h000000E1, 2'b00, 4'h0, 0, 3);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
